// File: rtl/uart_tx_if.sv
// Byte-write / serial-line bundle between the UART transmitter and its host.
interface uart_tx_if;
    logic       tx_en;
    logic       wr_en;
    logic [7:0] tx_data;
    logic       tx_out;
    logic       full;
    logic       busy;
    logic       tx_done;

    modport master (
        output tx_en, wr_en, tx_data,
        input  tx_out, full, busy, tx_done
    );

    modport slave (
        input  tx_en, wr_en, tx_data,
        output tx_out, full, busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one-entry holding register feeding a start/data/stop
// serialiser timed by the shared oversampling baud-tick enable.
module uart_tx #(
    parameter int unsigned SAMPLE_RATE = 16
) (
    input logic      clk,
    input logic      reset,
    uart_tx_if.slave bus
);

    localparam int unsigned   CW       = (SAMPLE_RATE > 2) ? $clog2(SAMPLE_RATE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_RATE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    idx_nxt;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          full_q, full_d;
    logic          tx_q, tx_d;
    logic          done;
    logic          bit_end;

    assign bit_end = bus.tx_en && (cnt_q == CNT_LAST);
    assign idx_nxt = idx_q + 3'd1;

    // State, counters, holding and shift registers; reset returns line to idle-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            tx_q    <= tx_d;
        end
    end

    // Write acceptance plus frame sequencing; tx_d is the line level for the next clk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        full_d  = full_q;
        tx_d    = tx_q;
        done    = 1'b0;

        // Acceptance (full_q==0) and loading (full_q==1) are mutually exclusive.
        if (bus.wr_en && !full_q) begin
            hold_d = bus.tx_data;
            full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (full_q) begin
                    shift_d = hold_q;
                    full_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bus.tx_en) begin
                    if (bit_end) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = DATA;
                        tx_d    = shift_q[0];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_d = shift_q[idx_q];
                if (bus.tx_en) begin
                    if (bit_end) begin
                        cnt_d = '0;
                        if (idx_q == 3'd7) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            idx_d = idx_nxt;
                            tx_d  = shift_q[idx_nxt];
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bus.tx_en) begin
                    if (bit_end) begin
                        cnt_d   = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign bus.tx_out  = tx_q;
    assign bus.full    = full_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.tx_done = done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-position model checked every cycle,
// directed scenarios with literal expectations, and a loopback deserialiser.
module tb_uart_tx;

    localparam int SR    = 16;
    localparam int FRAME = 10 * SR;

    logic clk = 1'b0;
    logic reset;

    uart_tx_if bus_if ();

    uart_tx #(.SAMPLE_RATE(SR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: timeout expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model: frame position in ticks ----------------
    bit         m_valid  = 1'b0;
    bit         m_active = 1'b0;
    bit         m_held   = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_cur    = '0;
    logic [7:0] m_hold   = '0;
    logic [7:0] loaded_q[$];

    function automatic logic exp_level(input logic [7:0] b, input int pos);
        int bi;
        bi = pos / SR;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit was_held;
        m_valid = 1'b1;
        if (reset) begin
            m_active = 1'b0;
            m_held   = 1'b0;
            m_pos    = 0;
        end else begin
            was_held = m_held;
            if (!m_active) begin
                if (m_held) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                    m_cur    = m_hold;
                    m_held   = 1'b0;
                    loaded_q.push_back(m_hold);
                end
            end else if (bus_if.tx_en) begin
                if (m_pos == FRAME - 1) m_active = 1'b0;
                else                    m_pos++;
            end
            if (bus_if.wr_en && !was_held) begin
                m_held = 1'b1;
                m_hold = bus_if.tx_data;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_tx_out", bus_if.tx_out, m_active ? exp_level(m_cur, m_pos) : 1'b1);
            check("cyc_busy", bus_if.busy, m_active);
            check("cyc_full", bus_if.full, m_held);
            check("cyc_tx_done", bus_if.tx_done,
                  m_active && (m_pos == FRAME - 1) && bus_if.tx_en);
        end
    end

    // ---------------- run-length / pulse monitors ----------------
    int done_cnt = 0;
    int brun = 0, irun = 0, lrun = 0;
    int last_busy_run = 0, last_idle_run = 0, last_low_run = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            if (bus_if.tx_done === 1'b1) done_cnt++;
            if (bus_if.busy === 1'b1) begin
                if (irun > 0) last_idle_run = irun;
                irun = 0;
                brun++;
            end else begin
                if (brun > 0) last_busy_run = brun;
                brun = 0;
                irun++;
            end
            if (bus_if.tx_out === 1'b0) begin
                lrun++;
            end else begin
                if (lrun > 0) last_low_run = lrun;
                lrun = 0;
            end
        end
    end

    // ---------------- loopback deserialiser (tx_en held high) ----------------
    bit         rx_on   = 1'b0;
    bit         rx_busy = 1'b0;
    int         rc      = 0;
    logic [7:0] rx_sh   = '0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (rx_on) begin
            if (!rx_busy) begin
                if (bus_if.tx_out === 1'b0) begin
                    rx_busy = 1'b1;
                    rc      = 0;
                end
            end else begin
                rc++;
                if ((rc % SR) == SR / 2 && rc >= SR + SR / 2 && rc <= 8 * SR + SR / 2)
                    rx_sh = {bus_if.tx_out, rx_sh[7:1]};
                if (rc == 9 * SR + SR / 2) begin
                    check("rx_stop_bit", bus_if.tx_out, 1'b1);
                    rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- tick generator ----------------
    int tick_div = 1;

    initial begin
        int ph;
        ph = 0;
        bus_if.tx_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % tick_div;
            bus_if.tx_en = (ph == 0);
        end
    end

    // ---------------- stimulus helpers (called at #1 after a posedge) ----------------
    task automatic write_byte(input logic [7:0] b);
        bus_if.wr_en   = 1'b1;
        bus_if.tx_data = b;
        @(posedge clk);
        #1;
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while ((bus_if.busy !== 1'b0 || bus_if.full !== 1'b0 || m_active || m_held) && k < budget) begin
            step(1);
            k++;
        end
        if (k >= budget) fail_timeout(name);
        step(2);
    endtask

    task automatic check_log(input string name, input logic [7:0] exp_q[$]);
        check({name, "_count"}, loaded_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < loaded_q.size(); i++)
            check({name, "_byte"}, loaded_q[i], exp_q[i]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] exp_q[$];
        logic [9:0] fb;
        logic [7:0] sent_q[$];
        logic [7:0] b;
        int         k;

        reset          = 1'b1;
        bus_if.wr_en   = 1'b0;
        bus_if.tx_data = '0;
        step(3);
        check("reset_tx_out", bus_if.tx_out, 1'b1);
        check("reset_full", bus_if.full, 1'b0);
        check("reset_busy", bus_if.busy, 1'b0);
        check("reset_tx_done", bus_if.tx_done, 1'b0);
        reset = 1'b0;
        step(2);

        // 1. single byte 0x55
        done_cnt = 0;
        loaded_q.delete();
        write_byte(8'h55);
        @(negedge clk);
        check("t1_full_latency", bus_if.full, 1'b1);
        check("t1_line_still_idle", bus_if.tx_out, 1'b1);
        @(negedge clk);
        check("t1_start_latency", bus_if.tx_out, 1'b0);
        fb = 10'b1010101010;
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? SR / 2 : SR) @(negedge clk);
            check("t1_frame_bit", bus_if.tx_out, fb[i]);
        end
        step(1);
        wait_idle("t1_idle", 400);
        check("t1_busy_len", last_busy_run, 160);
        check("t1_done_pulses", done_cnt, 1);
        exp_q = '{8'h55};
        check_log("t1_bytes", exp_q);

        // 2. back-to-back 0xA5 then 0x3C preloaded while busy
        done_cnt = 0;
        loaded_q.delete();
        write_byte(8'hA5);
        step(5);
        check("t2_busy_before_preload", bus_if.busy, 1'b1);
        write_byte(8'h3C);
        wait_idle("t2_idle", 800);
        check("t2_idle_gap", last_idle_run, 1);
        check("t2_busy_len", last_busy_run, 160);
        check("t2_done_pulses", done_cnt, 2);
        exp_q = '{8'hA5, 8'h3C};
        check_log("t2_bytes", exp_q);

        // 3a. overflow while a frame is active: first write held, the rest dropped
        loaded_q.delete();
        write_byte(8'h0F);
        step(3);
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        wait_idle("t3a_idle", 800);
        exp_q = '{8'h0F, 8'h11};
        check_log("t3a_bytes", exp_q);

        // 3b. three consecutive writes from idle: the middle one meets full=1
        loaded_q.delete();
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        wait_idle("t3b_idle", 800);
        exp_q = '{8'h11, 8'h33};
        check_log("t3b_bytes", exp_q);

        // 4. tick every 4th clk, byte 0xF0
        tick_div = 4;
        step(8);
        done_cnt = 0;
        loaded_q.delete();
        write_byte(8'hF0);
        wait_idle("t4_idle", 3000);
        check("t4_low_run_range", (last_low_run >= 317 && last_low_run <= 320), 1'b1);
        check("t4_busy_run_range", (last_busy_run >= 637 && last_busy_run <= 640), 1'b1);
        check("t4_done_pulses", done_cnt, 1);
        tick_div = 1;
        step(4);

        // 5. reset mid-frame in DATA index 3 with a byte held
        done_cnt = 0;
        write_byte(8'h5A);
        step(2);
        write_byte(8'h77);
        k = 0;
        while (!(m_active && m_pos == SR * 4 + 3) && k < 400) begin
            step(1);
            k++;
        end
        if (k >= 400) fail_timeout("t5_reach_data3");
        check("t5_full_before", bus_if.full, 1'b1);
        reset = 1'b1;
        step(1);
        check("t5_tx_out", bus_if.tx_out, 1'b1);
        check("t5_busy", bus_if.busy, 1'b0);
        check("t5_full", bus_if.full, 1'b0);
        reset = 1'b0;
        step(200);
        check("t5_no_done", done_cnt, 0);
        loaded_q.delete();
        write_byte(8'h81);
        wait_idle("t5_idle", 400);
        check("t5_done_after", done_cnt, 1);
        exp_q = '{8'h81};
        check_log("t5_bytes", exp_q);

        // 6. loopback of 256 random bytes through the bench deserialiser
        rx_q.delete();
        rx_on = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            k = 0;
            while (bus_if.full !== 1'b0 && k < 400) begin
                step(1);
                k++;
            end
            if (k >= 400) fail_timeout("t6_not_full");
            sent_q.push_back(b);
            write_byte(b);
        end
        wait_idle("t6_idle", 800);
        rx_on = 1'b0;
        check("t6_rx_count", rx_q.size(), 256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++)
            check("t6_rx_byte", rx_q[i], sent_q[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
